// File: rtl/ib_lut_pkg.sv
// ib_lut_pkg
// Shared definitions for the symmetric VN information-bottleneck LUT:
// default LUT word width, entries per page (one entry per load cycle)
// and the load/swap FSM state encoding.
package ib_lut_pkg;

    localparam int LUT_QUAN_SIZE = 3;   // default LUT word / load data width
    localparam int VN_LOAD_CYCLE = 32;  // entries per LUT page

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL
    } lut_state_e;

endpackage

// File: rtl/ib_lut_dist_page.sv
// ib_lut_dist_page
// One LUT page: a single write port shared by RD_PORT_NUM replicated
// distributed-RAM copies, each copy serving one combinational read port.
// Contents are not reset.
//   clk    : write clock
//   we     : write enable (writes every replica at waddr)
//   waddr  : write address
//   wdata  : write data
//   raddr  : packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rdata  : packed read data, port p at [p*QUAN_SIZE +: QUAN_SIZE];
//            0 when the port address is beyond the last entry
module ib_lut_dist_page
    import ib_lut_pkg::*;
#(
    parameter int QUAN_SIZE   = LUT_QUAN_SIZE,
    parameter int ENTRY_NUM   = VN_LOAD_CYCLE,
    parameter int ADDR_W      = $clog2(ENTRY_NUM),
    parameter int RD_PORT_NUM = 2
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [ADDR_W-1:0]               waddr,
    input  logic [QUAN_SIZE-1:0]            wdata,
    input  logic [RD_PORT_NUM*ADDR_W-1:0]   raddr,
    output logic [RD_PORT_NUM*QUAN_SIZE-1:0] rdata
);

    (* ram_style = "distributed" *)
    logic [QUAN_SIZE-1:0] mem_q [RD_PORT_NUM][ENTRY_NUM];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned p = 0; p < RD_PORT_NUM; p++) begin
                mem_q[p][waddr] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned p = 0; p < RD_PORT_NUM; p++) begin
            // ENTRY_NUM need not be a power of two, so guard the tail
            if (32'(raddr[p*ADDR_W +: ADDR_W]) < ENTRY_NUM) begin
                rdata[p*QUAN_SIZE +: QUAN_SIZE] = mem_q[p][raddr[p*ADDR_W +: ADDR_W]];
            end
        end
    end

endmodule

// File: rtl/sym_vn_lut_pingpong.sv
// sym_vn_lut_pingpong
// Ping-pong symmetric VN IB LUT. An active page serves RD_PORT_NUM
// zero-latency reads while a shadow page is filled serially over a
// valid/ready stream; a swap handshake exchanges the pages.
//   write_clk    : sole clock
//   rstn         : asynchronous active-low reset
//   load_start   : pulse, begin filling the shadow page from entry 0
//   load_valid   : load beat valid
//   load_data    : LUT entry for the current load address
//   load_ready   : shadow page accepting beats (LOAD state)
//   load_done    : shadow page full, awaiting swap (FULL state)
//   swap_req     : pulse, request page exchange
//   swap_ack     : one-cycle pulse, swap performed
//   swap_err     : one-cycle pulse, swap_req rejected (not FULL)
//   active_valid : active page holds a complete LUT
//   read_addr    : packed read addresses
//   lut_data     : packed read data, 0 while active_valid is low
module sym_vn_lut_pingpong
    import ib_lut_pkg::*;
#(
    parameter int QUAN_SIZE   = LUT_QUAN_SIZE,
    parameter int ENTRY_NUM   = VN_LOAD_CYCLE,
    parameter int ADDR_W      = $clog2(ENTRY_NUM),
    parameter int RD_PORT_NUM = 2
) (
    input  logic                             write_clk,
    input  logic                             rstn,
    input  logic                             load_start,
    input  logic                             load_valid,
    input  logic [QUAN_SIZE-1:0]             load_data,
    output logic                             load_ready,
    output logic                             load_done,
    input  logic                             swap_req,
    output logic                             swap_ack,
    output logic                             swap_err,
    output logic                             active_valid,
    input  logic [RD_PORT_NUM*ADDR_W-1:0]    read_addr,
    output logic [RD_PORT_NUM*QUAN_SIZE-1:0] lut_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRY_NUM - 1);

    lut_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              active_bank_q, active_bank_d;
    logic              active_valid_q, active_valid_d;
    logic              swap_ack_q, swap_ack_d;
    logic              swap_err_q, swap_err_d;

    logic              beat;
    logic              we0, we1;
    logic [RD_PORT_NUM*QUAN_SIZE-1:0] rd0, rd1;

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            wr_cnt_q       <= '0;
            active_bank_q  <= 1'b0;
            active_valid_q <= 1'b0;
            swap_ack_q     <= 1'b0;
            swap_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            active_bank_q  <= active_bank_d;
            active_valid_q <= active_valid_d;
            swap_ack_q     <= swap_ack_d;
            swap_err_q     <= swap_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        active_bank_d  = active_bank_q;
        active_valid_d = active_valid_q;
        swap_ack_d     = 1'b0;
        swap_err_d     = 1'b0;
        load_ready     = 1'b0;
        load_done      = 1'b0;
        beat           = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_cnt_d = '0;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                beat       = load_valid;
                if (beat) begin
                    if (wr_cnt_q == LAST_ADDR) begin
                        state_d  = FULL;
                        wr_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            FULL: begin
                load_done = 1'b1;
                if (swap_req) begin
                    active_bank_d  = ~active_bank_q;
                    active_valid_d = 1'b1;
                    swap_ack_d     = 1'b1;
                    // back-to-back reload of the page that was just retired
                    state_d        = load_start ? LOAD : IDLE;
                    wr_cnt_d       = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (swap_req && state_q != FULL) begin
            swap_err_d = 1'b1;
        end
    end

    // only the shadow bank is ever written
    assign we0 = beat &  active_bank_q;
    assign we1 = beat & ~active_bank_q;

    ib_lut_dist_page #(
        .QUAN_SIZE   (QUAN_SIZE),
        .ENTRY_NUM   (ENTRY_NUM),
        .ADDR_W      (ADDR_W),
        .RD_PORT_NUM (RD_PORT_NUM)
    ) u_bank0 (
        .clk   (write_clk),
        .we    (we0),
        .waddr (wr_cnt_q),
        .wdata (load_data),
        .raddr (read_addr),
        .rdata (rd0)
    );

    ib_lut_dist_page #(
        .QUAN_SIZE   (QUAN_SIZE),
        .ENTRY_NUM   (ENTRY_NUM),
        .ADDR_W      (ADDR_W),
        .RD_PORT_NUM (RD_PORT_NUM)
    ) u_bank1 (
        .clk   (write_clk),
        .we    (we1),
        .waddr (wr_cnt_q),
        .wdata (load_data),
        .raddr (read_addr),
        .rdata (rd1)
    );

    always_comb begin
        lut_data = '0;
        if (active_valid_q) begin
            lut_data = active_bank_q ? rd1 : rd0;
        end
    end

    assign swap_ack     = swap_ack_q;
    assign swap_err     = swap_err_q;
    assign active_valid = active_valid_q;

endmodule

// File: tb/tb_sym_vn_lut_pingpong.sv
// tb_sym_vn_lut_pingpong
// Directed bench: a 32-entry instance exercising load, swap, ping-pong
// isolation, rejected swaps, swap+reload and reset mid-load, plus a
// 20-entry instance for the non-power-of-two address tail.
module tb_sym_vn_lut_pingpong;

    logic       clk;
    logic       rstn;

    // 32-entry DUT
    logic       load_start, load_valid, swap_req;
    logic [2:0] load_data;
    logic       load_ready, load_done, swap_ack, swap_err, active_valid;
    logic [9:0] read_addr;
    logic [5:0] lut_data;

    // 20-entry DUT
    logic       b_load_start, b_load_valid, b_swap_req;
    logic [2:0] b_load_data;
    logic       b_load_ready, b_load_done, b_swap_ack, b_swap_err, b_active_valid;
    logic [9:0] b_read_addr;
    logic [5:0] b_lut_data;

    int n_cmp = 0;
    int n_bad = 0;

    sym_vn_lut_pingpong #(
        .QUAN_SIZE   (3),
        .ENTRY_NUM   (32),
        .ADDR_W      (5),
        .RD_PORT_NUM (2)
    ) dut (
        .write_clk    (clk),
        .rstn         (rstn),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .load_done    (load_done),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .swap_err     (swap_err),
        .active_valid (active_valid),
        .read_addr    (read_addr),
        .lut_data     (lut_data)
    );

    sym_vn_lut_pingpong #(
        .QUAN_SIZE   (3),
        .ENTRY_NUM   (20),
        .ADDR_W      (5),
        .RD_PORT_NUM (2)
    ) dut20 (
        .write_clk    (clk),
        .rstn         (rstn),
        .load_start   (b_load_start),
        .load_valid   (b_load_valid),
        .load_data    (b_load_data),
        .load_ready   (b_load_ready),
        .load_done    (b_load_done),
        .swap_req     (b_swap_req),
        .swap_ack     (b_swap_ack),
        .swap_err     (b_swap_err),
        .active_valid (b_active_valid),
        .read_addr    (b_read_addr),
        .lut_data     (b_lut_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock, then settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] pat(input int mode, input int k);
        case (mode)
            0:       return 3'(k % 8);
            1:       return 3'(7 - (k % 8));
            default: return 3'd5;
        endcase
    endfunction

    // Load nbeats entries; exp3 >= 0 checks port0 (addr 3) every beat.
    task automatic load_page(input bit do_start, input int mode, input int nbeats,
                             input bit gap, input bit swap_last, input int exp3);
        if (do_start) begin
            load_start = 1'b1;
            step();
            load_start = 1'b0;
        end
        check("load_ready_at_start", load_ready, 1);
        for (int k = 0; k < nbeats; k++) begin
            load_valid = 1'b1;
            load_data  = pat(mode, k);
            if (swap_last && k == 31) swap_req = 1'b1;
            #1;
            if (exp3 >= 0) check("isolation_addr3", lut_data[2:0], exp3);
            if (k == 31) check("load_done_before_last", load_done, 0);
            step();
            load_valid = 1'b0;
            swap_req   = 1'b0;
            if (gap) step();
        end
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("swap_ack", swap_ack, 1);
        check("swap_err_clear", swap_err, 0);
        check("active_valid", active_valid, 1);
    endtask

    initial begin
        rstn = 1'b0;
        load_start = 0; load_valid = 0; swap_req = 0; load_data = '0;
        b_load_start = 0; b_load_valid = 0; b_swap_req = 0; b_load_data = '0;
        read_addr = {5'd31, 5'd5};
        b_read_addr = '0;
        step(); step();
        check("rst_lut_data", lut_data, 0);
        check("rst_active_valid", active_valid, 0);
        rstn = 1'b1;
        step();

        // 1: idle after reset
        read_addr = {5'd7, 5'd3};
        #1;
        check("idle_lut_data", lut_data, 0);
        check("idle_active_valid", active_valid, 0);
        check("idle_load_ready", load_ready, 0);
        check("idle_load_done", load_done, 0);
        check("idle_swap_ack", swap_ack, 0);

        // 2: first load with gapped valid, then swap
        load_page(1, 0, 32, 1, 0, 0);
        check("t2_load_done", load_done, 1);
        check("t2_load_ready", load_ready, 0);
        check("t2_still_invalid", lut_data, 0);
        read_addr = {5'd31, 5'd5};
        do_swap();
        check("t2_port0_addr5", lut_data[2:0], 5);
        check("t2_port1_addr31", lut_data[5:3], 7);
        check("t2_load_done_after_swap", load_done, 0);
        step();
        check("t2_swap_ack_pulse", swap_ack, 0);

        // 3: ping-pong, page B = 7-(k%8) while page A serves reads
        read_addr = {5'd0, 5'd3};
        load_page(1, 1, 32, 0, 0, 3);
        check("t3_before_swap", lut_data[2:0], 3);
        do_swap();
        check("t3_port0_addr3", lut_data[2:0], 4);
        check("t3_port1_addr0", lut_data[5:3], 7);

        // 4: swap_req on the final beat is rejected
        load_page(1, 0, 32, 0, 1, 4);
        check("t4_swap_err", swap_err, 1);
        check("t4_no_swap_ack", swap_ack, 0);
        check("t4_load_done", load_done, 1);
        check("t4_reads_unchanged", lut_data[2:0], 4);
        do_swap();
        check("t4_port0_addr3", lut_data[2:0], 3);

        // 5: swap + load_start together, reload the retired page
        load_page(1, 1, 32, 0, 0, 3);
        swap_req = 1'b1;
        load_start = 1'b1;
        step();
        swap_req = 1'b0;
        load_start = 1'b0;
        check("t5_swap_ack", swap_ack, 1);
        check("t5_load_ready", load_ready, 1);
        check("t5_new_active_addr3", lut_data[2:0], 4);
        read_addr = {5'd31, 5'd3};
        load_page(0, 2, 32, 0, 0, 4);
        check("t5_port1_addr31_unchanged", lut_data[5:3], 0);
        check("t5_load_done", load_done, 1);
        do_swap();
        check("t5_port0_after", lut_data[2:0], 5);
        check("t5_port1_after", lut_data[5:3], 5);

        // 6: reset in the middle of a reload
        load_page(1, 0, 10, 0, 0, 5);
        rstn = 1'b0;
        #1;
        check("t6_active_valid", active_valid, 0);
        check("t6_lut_data", lut_data, 0);
        check("t6_load_ready", load_ready, 0);
        check("t6_load_done", load_done, 0);
        step();
        rstn = 1'b1;
        step();
        load_page(1, 0, 32, 0, 0, 0);
        read_addr = {5'd31, 5'd5};
        do_swap();
        check("t6_port0_addr5", lut_data[2:0], 5);
        check("t6_port1_addr31", lut_data[5:3], 7);

        // 20-entry build: tail addresses read as 0
        b_load_start = 1'b1;
        step();
        b_load_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            b_load_valid = 1'b1;
            b_load_data  = 3'(k % 8);
            step();
        end
        b_load_valid = 1'b0;
        check("e20_load_done", b_load_done, 1);
        b_swap_req = 1'b1;
        step();
        b_swap_req = 1'b0;
        check("e20_swap_ack", b_swap_ack, 1);
        b_read_addr = {5'd25, 5'd19};
        #1;
        check("e20_addr19", b_lut_data[2:0], 3);
        check("e20_addr25", b_lut_data[5:3], 0);
        b_read_addr = {5'd20, 5'd12};
        #1;
        check("e20_addr12", b_lut_data[2:0], 4);
        check("e20_addr20", b_lut_data[5:3], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
